// File: rtl/prt_dp_pm_pkg.sv
// Shared definitions for the PM timeout scheduler: parameter defaults and FSM state codes.
package prt_dp_pm_pkg;

  localparam int PM_REQ_DEF       = 4;
  localparam int PM_CNT_WIDTH_DEF = 32;

  typedef logic [1:0] tsch_state_t;

  localparam tsch_state_t ST_IDLE  = 2'd0;
  localparam tsch_state_t ST_GRANT = 2'd1;
  localparam tsch_state_t ST_RUN   = 2'd2;
  localparam tsch_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/prt_dp_lib_edge.sv
// Library cell: rising-edge detector for a level signal already synchronous to clk.
module prt_dp_lib_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_out
);

  logic sig_q;
  logic sig_d;

  // Next value of the history flop is simply the current level.
  always_comb begin
    sig_d = sig_in;
  end

  // Keep last cycle's level so a low-to-high change can be seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise_out = sig_in & ~sig_q;

endmodule

// File: rtl/prt_dp_pm_tsch_rr.sv
// Round-robin picker: first set request at or after the pointer, wrapping around.
module prt_dp_pm_tsch_rr
  import prt_dp_pm_pkg::*;
#(
  parameter int P_REQ = PM_REQ_DEF,
  parameter int IDX_W = $clog2(P_REQ)
) (
  input  logic [P_REQ-1:0] req_in,
  input  logic [IDX_W-1:0] ptr_in,
  output logic [P_REQ-1:0] gnt_oh_out,
  output logic [IDX_W-1:0] gnt_idx_out
);

  logic [IDX_W:0]   pos_sum;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_oh_out  = '0;
    gnt_idx_out = '0;
    found       = 1'b0;
    pos_sum     = '0;
    pos_idx     = '0;
    for (int i = 0; i < P_REQ; i++) begin
      pos_sum = {1'b0, ptr_in} + (IDX_W+1)'(i);
      if (pos_sum >= (IDX_W+1)'(P_REQ)) begin
        pos_sum = pos_sum - (IDX_W+1)'(P_REQ);
      end
      pos_idx = pos_sum[IDX_W-1:0];
      if (!found && req_in[pos_idx]) begin
        found               = 1'b1;
        gnt_oh_out[pos_idx] = 1'b1;
        gnt_idx_out         = pos_idx;
      end
    end
  end

endmodule

// File: rtl/prt_dp_pm_tsch.sv
// PM timeout scheduler: one shared microsecond down-counter served to requesters in turn.
module prt_dp_pm_tsch
  import prt_dp_pm_pkg::*;
#(
  parameter int P_REQ       = PM_REQ_DEF,
  parameter int P_CNT_WIDTH = PM_CNT_WIDTH_DEF
) (
  input  logic                         CLK_IN,
  input  logic                         RST_IN,
  input  logic                         BEAT_IN,
  input  logic [P_REQ-1:0]             REQ_IN,
  input  logic [P_REQ*P_CNT_WIDTH-1:0] DUR_IN,
  input  logic [P_REQ-1:0]             CANCEL_IN,
  output logic [P_REQ-1:0]             ACK_OUT,
  output logic [P_REQ-1:0]             DONE_OUT,
  output logic                         BUSY_OUT,
  output logic [$clog2(P_REQ)-1:0]     GNT_OUT
);

  localparam int IDX_W = $clog2(P_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_REQ-1);

  tsch_state_t            state_q, state_d;
  logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [P_REQ-1:0]       win_oh_q, win_oh_d;

  logic [P_REQ-1:0]       rr_oh;
  logic [IDX_W-1:0]       rr_idx;
  logic                   beat_rise;
  logic                   cancel_hit;
  logic [IDX_W-1:0]       win_next;
  logic [P_CNT_WIDTH-1:0] dur_sel;

  prt_dp_pm_tsch_rr #(
    .P_REQ (P_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_in      (REQ_IN),
    .ptr_in      (ptr_q),
    .gnt_oh_out  (rr_oh),
    .gnt_idx_out (rr_idx)
  );

  prt_dp_lib_edge u_beat_edge (
    .clk      (CLK_IN),
    .rst_n    (RST_IN),
    .sig_in   (BEAT_IN),
    .rise_out (beat_rise)
  );

  // Only the active winner's cancel matters; the pointer always moves past the winner.
  always_comb begin
    cancel_hit = |(CANCEL_IN & win_oh_q);
    win_next   = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
  end

  // Pick the winner's duration slice out of the packed duration bus.
  always_comb begin
    dur_sel = '0;
    for (int i = 0; i < P_REQ; i++) begin
      if (win_q == IDX_W'(i)) begin
        dur_sel = DUR_IN[i*P_CNT_WIDTH +: P_CNT_WIDTH];
      end
    end
  end

  // Scheduler FSM: select, load, count beats, report; cancel beats expiry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    win_oh_d = win_oh_q;
    case (state_q)
      ST_IDLE: begin
        if (|REQ_IN) begin
          win_d    = rr_idx;
          win_oh_d = rr_oh;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cancel_hit) begin
          ptr_d   = win_next;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = dur_sel;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cancel_hit) begin
          ptr_d   = win_next;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (beat_rise) begin
          cnt_d = cnt_q - P_CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = win_next;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any timeout in flight.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      win_oh_q <= win_oh_d;
    end
  end

  // Pulses and status come straight from the registered state and winner.
  always_comb begin
    ACK_OUT  = (state_q == ST_GRANT) ? win_oh_q : '0;
    DONE_OUT = (state_q == ST_DONE)  ? win_oh_q : '0;
    BUSY_OUT = (state_q == ST_GRANT) || (state_q == ST_RUN);
    GNT_OUT  = win_q;
  end

endmodule

// File: tb/tb_prt_dp_pm_tsch.sv
// Self-checking bench for the PM timeout scheduler against a timestamp-based reference model.
module tb_prt_dp_pm_tsch;
  import prt_dp_pm_pkg::*;

  localparam int P_REQ       = PM_REQ_DEF;
  localparam int P_CNT_WIDTH = PM_CNT_WIDTH_DEF;
  localparam int IDX_W       = $clog2(P_REQ);

  localparam int M_IDLE = 0;
  localparam int M_ONCE = 1;
  localparam int M_HOLD = 2;
  localparam int M_RAND = 3;

  logic                         CLK_IN = 1'b0;
  logic                         RST_IN = 1'b0;
  logic                         BEAT_IN = 1'b0;
  logic [P_REQ-1:0]             REQ_IN = '0;
  logic [P_REQ*P_CNT_WIDTH-1:0] DUR_IN = '0;
  logic [P_REQ-1:0]             CANCEL_IN = '0;
  logic [P_REQ-1:0]             ACK_OUT;
  logic [P_REQ-1:0]             DONE_OUT;
  logic                         BUSY_OUT;
  logic [IDX_W-1:0]             GNT_OUT;

  prt_dp_pm_tsch #(
    .P_REQ       (P_REQ),
    .P_CNT_WIDTH (P_CNT_WIDTH)
  ) dut (
    .CLK_IN    (CLK_IN),
    .RST_IN    (RST_IN),
    .BEAT_IN   (BEAT_IN),
    .REQ_IN    (REQ_IN),
    .DUR_IN    (DUR_IN),
    .CANCEL_IN (CANCEL_IN),
    .ACK_OUT   (ACK_OUT),
    .DONE_OUT  (DONE_OUT),
    .BUSY_OUT  (BUSY_OUT),
    .GNT_OUT   (GNT_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // stimulus knobs
  int               mode = M_IDLE;
  logic [P_REQ-1:0] pattern = '0;
  int               dur_val = 0;
  int               beat_half = 5;
  int               beat_cnt = 0;
  bit               cancel_test = 1'b0;
  bit               did_c3 = 1'b0;
  bit               did_c0 = 1'b0;
  logic [P_REQ-1:0] acked = '0;

  // reference model: one timeout in flight, tracked by cycle timestamps
  bit m_active = 1'b0;
  int m_idx = 0;
  int m_ack_cyc = -1;
  int m_done_cyc = -1;
  int m_dur = 0;
  int m_edges = 0;
  int m_ptr = 0;
  int m_gnt = 0;
  bit m_prev_beat = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Requester nearest to the pointer in circular distance wins.
  function automatic int rrPick(input logic [P_REQ-1:0] r, input int ptr);
    int best;
    int best_dist;
    int d;
    best = -1;
    best_dist = P_REQ;
    for (int j = 0; j < P_REQ; j++) begin
      if (r[j]) begin
        d = (j - ptr + P_REQ) % P_REQ;
        if (d < best_dist) begin
          best_dist = d;
          best = j;
        end
      end
    end
    return best;
  endfunction

  task automatic setDur(input int v);
    for (int i = 0; i < P_REQ; i++) DUR_IN[i*P_CNT_WIDTH +: P_CNT_WIDTH] = P_CNT_WIDTH'(v);
  endtask

  task automatic modelStep(input int k);
    bit rise;
    rise = BEAT_IN && !m_prev_beat;
    m_prev_beat = BEAT_IN;
    if (m_active) begin
      if (k == m_done_cyc) begin
        m_active = 1'b0;
        m_ptr = (m_idx + 1) % P_REQ;
      end else if (CANCEL_IN[m_idx]) begin
        m_active = 1'b0;
        m_ptr = (m_idx + 1) % P_REQ;
      end else if (k == m_ack_cyc) begin
        m_dur = int'(DUR_IN[m_idx*P_CNT_WIDTH +: P_CNT_WIDTH]);
        m_edges = 0;
        if (m_dur == 0) m_done_cyc = k + 2;
      end else if (m_done_cyc < 0 && rise) begin
        m_edges++;
        if (m_edges == m_dur) m_done_cyc = k + 2;
      end
    end else if (REQ_IN != '0) begin
      m_idx = rrPick(REQ_IN, m_ptr);
      m_active = 1'b1;
      m_ack_cyc = k + 1;
      m_done_cyc = -1;
      m_edges = 0;
      m_gnt = m_idx;
    end
  endtask

  task automatic checkAll();
    logic [P_REQ-1:0] e_ack;
    logic [P_REQ-1:0] e_done;
    bit e_busy;
    e_ack = '0;
    e_done = '0;
    if (m_active && cyc == m_ack_cyc) e_ack[m_idx] = 1'b1;
    if (m_active && cyc == m_done_cyc) e_done[m_idx] = 1'b1;
    e_busy = m_active && (cyc != m_done_cyc);
    checkOutput("ack", 32'(ACK_OUT), 32'(e_ack));
    checkOutput("done", 32'(DONE_OUT), 32'(e_done));
    checkOutput("busy", 32'(BUSY_OUT), 32'(e_busy));
    checkOutput("gnt", 32'(GNT_OUT), 32'(m_gnt));
    acked = e_ack;
  endtask

  task automatic applyStimulus();
    beat_cnt++;
    if (beat_cnt >= beat_half) begin
      BEAT_IN = ~BEAT_IN;
      beat_cnt = 0;
      if (mode == M_RAND) beat_half = $urandom_range(1, 4);
    end
    CANCEL_IN = '0;
    case (mode)
      M_IDLE: REQ_IN = '0;
      M_HOLD: REQ_IN = pattern;
      M_ONCE: begin
        REQ_IN = REQ_IN & ~acked;
        if (cancel_test && m_active && m_idx == 0 && cyc > m_ack_cyc) begin
          if (m_edges == 2 && !did_c3) begin
            CANCEL_IN[P_REQ-1] = 1'b1;
            did_c3 = 1'b1;
          end else if (m_edges == 4 && !did_c0) begin
            CANCEL_IN[0] = 1'b1;
            did_c0 = 1'b1;
          end
        end
      end
      default: begin
        for (int i = 0; i < P_REQ; i++) begin
          if (acked[i] && $urandom_range(0, 3) != 0) REQ_IN[i] = 1'b0;
          else if (!REQ_IN[i] && $urandom_range(0, 7) == 0) REQ_IN[i] = 1'b1;
          else if (REQ_IN[i] && $urandom_range(0, 59) == 0) REQ_IN[i] = 1'b0;
          DUR_IN[i*P_CNT_WIDTH +: P_CNT_WIDTH] = P_CNT_WIDTH'($urandom_range(0, 4));
        end
        if ($urandom_range(0, 24) == 0) CANCEL_IN = P_REQ'($urandom);
      end
    endcase
  endtask

  task automatic oneCycle();
    applyStimulus();
    modelStep(cyc);
    cyc++;
    @(negedge CLK_IN);
    checkAll();
  endtask

  task automatic runPhase(input int m, input logic [P_REQ-1:0] pat, input int dur,
                          input int half, input int ncyc);
    mode = m;
    pattern = pat;
    dur_val = dur;
    beat_half = half;
    acked = '0;
    setDur(dur);
    if (m == M_ONCE) REQ_IN = pat;
    repeat (ncyc) oneCycle();
  endtask

  // Called at a falling edge; outputs must clear as soon as reset drops.
  task automatic doReset(input int ncyc);
    RST_IN = 1'b0;
    REQ_IN = '0;
    CANCEL_IN = '0;
    #1;
    checkOutput("rst_ack", 32'(ACK_OUT), 32'd0);
    checkOutput("rst_done", 32'(DONE_OUT), 32'd0);
    checkOutput("rst_busy", 32'(BUSY_OUT), 32'd0);
    checkOutput("rst_gnt", 32'(GNT_OUT), 32'd0);
    m_active = 1'b0;
    m_ptr = 0;
    m_gnt = 0;
    m_prev_beat = 1'b0;
    acked = '0;
    repeat (ncyc) begin
      @(negedge CLK_IN);
      checkOutput("rst_hold_busy", 32'(BUSY_OUT), 32'd0);
    end
    RST_IN = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    doReset(3);
    // quiet system with the beat running
    runPhase(M_IDLE, '0, 0, 5, 1000);
    // single request on requester 1, duration 3
    runPhase(M_ONCE, 4'b0010, 3, 5, 80);
    // all held, duration 1, from a fresh pointer
    doReset(2);
    runPhase(M_HOLD, 4'b1111, 1, 2, 120);
    runPhase(M_IDLE, '0, 0, 2, 20);
    // zero duration on requester 2
    runPhase(M_ONCE, 4'b0100, 0, 5, 40);
    // cancel of requester 0 mid-run, stray cancel of requester 3 earlier
    cancel_test = 1'b1;
    runPhase(M_ONCE, 4'b0001, 10, 3, 100);
    cancel_test = 1'b0;
    runPhase(M_ONCE, 4'b1111, 1, 2, 80);
    // reset in the middle of a long timeout
    runPhase(M_ONCE, 4'b0001, 100, 3, 60);
    doReset(3);
    runPhase(M_ONCE, 4'b1111, 0, 3, 60);
    // randomized traffic with moving durations and cancels
    runPhase(M_RAND, '0, 0, 2, 4000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
